bilheteria_recarga: RTL and testbench

// - Fare-machine side of the turnstile credit interface: accepts coins, sells N passes, writes them to card 1 or 2.
// - Delivers each sale to the turnstile through a valid/ready load handshake.
// - Returns leftover coin credit as change pulses.
// - Sits beside the turnstile FSM in top; SWI drives coins/selection, and SEG/LED show saldo and state.

---
 rtl/bilheteria_recarga.sv | 144 ++++++++++++++
 tb/tb_bilheteria_recarga.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bilheteria_recarga.sv
// Fare-machine credit side: takes coins, sells passes to card 1/2, hands loads to the
// turnstile over valid/ready and pays leftover credit as change pulses. Refund: BILHETERIA_CANCELA_EN.
module bilheteria_recarga #(
    parameter int PRECO     = 2,
    parameter int MAX_SALDO = 15
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [1:0] moeda,
    input  logic       sel_cartao,
    input  logic [1:0] qtd,
    input  logic       confirma,
    input  logic       cancela,
    output logic       carga_valid,
    input  logic       carga_ready,
    output logic       carga_cartao,
    output logic [1:0] carga_qtd,
    output logic       troco,
    output logic [3:0] saldo,
    output logic [1:0] estado_dbg,
    output logic       erro
);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        PAGANDO    = 2'd1,
        CARREGANDO = 2'd2,
        TROCO      = 2'd3
    } estado_t;

    estado_t    estado, estado_next;
    logic [3:0] saldo_next;
    logic       cartao_next;
    logic [1:0] qtd_next;
    logic       erro_next;
    logic       valid_next;

    logic [4:0] valor;
    logic [4:0] soma;
    logic [4:0] custo;
    logic       tem_moeda;

    function automatic logic [4:0] valor_moeda(input logic [1:0] m);
        case (m)
            2'b01:   return 5'd1;
            2'b10:   return 5'd2;
            2'b11:   return 5'd5;
            default: return 5'd0;
        endcase
    endfunction

    // Sum kept 5 bits wide so an overflowing coin is visible before it is accepted.
    assign valor     = valor_moeda(moeda);
    assign soma      = {1'b0, saldo} + valor;
    assign custo     = 5'(qtd) * 5'(PRECO);
    assign tem_moeda = (moeda != 2'b00);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        estado_next = estado;
        saldo_next  = saldo;
        cartao_next = carga_cartao;
        qtd_next    = carga_qtd;
        erro_next   = 1'b0;

        case (estado)
            OCIOSO: begin
                if (tem_moeda) begin
                    saldo_next  = soma[3:0];
                    estado_next = PAGANDO;
                end
            end

            PAGANDO: begin
`ifdef BILHETERIA_CANCELA_EN
                if (cancela) begin
                    estado_next = TROCO;
                    erro_next   = tem_moeda;
                end else
`endif
                if (confirma) begin
                    // A coin arriving with confirma is refused; the sale uses pre-coin credit.
                    erro_next = tem_moeda;
                    if (qtd != 2'd0 && {1'b0, saldo} >= custo) begin
                        cartao_next = sel_cartao;
                        qtd_next    = qtd;
                        saldo_next  = saldo - custo[3:0];
                        estado_next = CARREGANDO;
                    end else begin
                        erro_next = 1'b1;
                    end
                end else if (tem_moeda) begin
                    if (soma > 5'(MAX_SALDO)) begin
                        erro_next = 1'b1;
                    end else begin
                        saldo_next = soma[3:0];
                    end
                end
            end

            CARREGANDO: begin
                erro_next = tem_moeda;
                if (carga_ready) begin
                    estado_next = (saldo != 4'd0) ? TROCO : OCIOSO;
                end
            end

            TROCO: begin
                erro_next  = tem_moeda;
                saldo_next = saldo - 4'd1;
                if (saldo == 4'd1) begin
                    estado_next = OCIOSO;
                end
            end

            default: estado_next = OCIOSO;
        endcase

        valid_next = (estado_next == CARREGANDO);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            estado       <= OCIOSO;
            saldo        <= 4'd0;
            carga_valid  <= 1'b0;
            carga_cartao <= 1'b0;
            carga_qtd    <= 2'd0;
            erro         <= 1'b0;
        end else begin
            estado       <= estado_next;
            saldo        <= saldo_next;
            carga_valid  <= valid_next;
            carga_cartao <= cartao_next;
            carga_qtd    <= qtd_next;
            erro         <= erro_next;
        end
    end

    assign troco      = (estado == TROCO);
    assign estado_dbg = estado;

endmodule

// File: tb/tb_bilheteria_recarga.sv
// Bench for bilheteria_recarga: directed scenarios then random traffic, all checked every
// cycle against a credit-ledger reference model (honours BILHETERIA_CANCELA_EN).
module tb_bilheteria_recarga;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [1:0] moeda;
    logic       sel_cartao;
    logic [1:0] qtd;
    logic       confirma;
    logic       cancela;
    logic       carga_valid;
    logic       carga_ready;
    logic       carga_cartao;
    logic [1:0] carga_qtd;
    logic       troco;
    logic [3:0] saldo;
    logic [1:0] estado_dbg;
    logic       erro;

    int checks   = 0;
    int failures = 0;

    // Reference ledger: phase 0 idle, 1 paying, 2 loading, 3 paying change.
    int coin_val [4] = '{0, 1, 2, 5};
    int m_phase  = 0;
    int m_credit = 0;
    int m_card   = 0;
    int m_qtd    = 0;
    int m_erro   = 0;

    bilheteria_recarga dut (
        .clk_2        (clk_2),
        .reset        (reset),
        .moeda        (moeda),
        .sel_cartao   (sel_cartao),
        .qtd          (qtd),
        .confirma     (confirma),
        .cancela      (cancela),
        .carga_valid  (carga_valid),
        .carga_ready  (carga_ready),
        .carga_cartao (carga_cartao),
        .carga_qtd    (carga_qtd),
        .troco        (troco),
        .saldo        (saldo),
        .estado_dbg   (estado_dbg),
        .erro         (erro)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int v;
        int cost;
        bit cancel_en;
`ifdef BILHETERIA_CANCELA_EN
        cancel_en = 1'b1;
`else
        cancel_en = 1'b0;
`endif
        v      = coin_val[moeda];
        m_erro = 0;
        if (reset) begin
            m_phase = 0; m_credit = 0; m_card = 0; m_qtd = 0;
            return;
        end
        case (m_phase)
            0: if (v > 0) begin m_credit += v; m_phase = 1; end
            1: begin
                cost = int'(qtd) * 2;
                if (cancel_en && cancela) begin
                    m_phase = 3;
                    m_erro  = (v > 0);
                end else if (confirma) begin
                    m_erro = (v > 0);
                    if (qtd != 0 && m_credit >= cost) begin
                        m_card = sel_cartao; m_qtd = qtd;
                        m_credit -= cost;
                        m_phase = 2;
                    end else m_erro = 1;
                end else if (v > 0) begin
                    if (m_credit + v > 15) m_erro = 1;
                    else m_credit += v;
                end
            end
            2: begin
                m_erro = (v > 0);
                if (carga_ready) m_phase = (m_credit > 0) ? 3 : 0;
            end
            default: begin
                m_erro = (v > 0);
                m_credit--;
                if (m_credit == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic check_all();
        check("estado", 8'(estado_dbg), 8'(m_phase));
        check("saldo", 8'(saldo), 8'(m_credit));
        check("valid", 8'(carga_valid), 8'(m_phase == 2));
        check("troco", 8'(troco), 8'(m_phase == 3));
        check("erro", 8'(erro), 8'(m_erro));
        check("cartao", 8'(carga_cartao), 8'(m_card));
        check("qtd", 8'(carga_qtd), 8'(m_qtd));
    endtask

    task automatic tick(input logic [1:0] m, input logic s, input logic [1:0] q,
                        input logic c, input logic k, input logic r, input logic rs);
        moeda = m; sel_cartao = s; qtd = q; confirma = c; cancela = k;
        carga_ready = r; reset = rs;
        @(posedge clk_2);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int troco_cycles;
        // Reset
        tick(2'b00, 0, 2'd0, 0, 0, 0, 1);
        tick(2'b00, 0, 2'd0, 1, 0, 0, 1);
        check("reset_saldo", 8'(saldo), 8'd0);
        tick(2'b00, 0, 2'd1, 1, 0, 0, 0);
        check("idle_confirma_no_erro", 8'(erro), 8'd0);

        // Exact payment, no change
        tick(2'b10, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b10, 0, 2'd0, 0, 0, 0, 0);
        check("saldo_4", 8'(saldo), 8'd4);
        tick(2'b00, 1, 2'd2, 1, 0, 0, 0);
        check("load_valid", 8'(carga_valid), 8'd1);
        check("load_card", 8'(carga_cartao), 8'd1);
        check("load_qtd", 8'(carga_qtd), 8'd2);
        check("load_saldo", 8'(saldo), 8'd0);
        tick(2'b00, 0, 2'd0, 0, 0, 1, 0);
        check("back_idle", 8'(estado_dbg), 8'd0);
        check("no_troco", 8'(troco), 8'd0);

        // Overpayment: 5 units, one pass, three change pulses
        tick(2'b11, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b00, 0, 2'd1, 1, 0, 0, 0);
        troco_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick(2'b00, 0, 2'd0, 0, 0, 1, 0);
            if (troco) troco_cycles++;
        end
        check("troco_cycles", 8'(troco_cycles), 8'd3);
        check("after_troco_idle", 8'(estado_dbg), 8'd0);

        // Insufficient credit and qtd 0
        tick(2'b01, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b00, 0, 2'd1, 1, 0, 0, 0);
        check("short_erro", 8'(erro), 8'd1);
        check("short_saldo", 8'(saldo), 8'd1);
        tick(2'b00, 0, 2'd0, 0, 0, 0, 0);
        check("erro_one_cycle", 8'(erro), 8'd0);
        tick(2'b00, 0, 2'd0, 1, 0, 0, 0);
        check("qtd0_erro", 8'(erro), 8'd1);

        // Backpressure: ready low 4 cycles
        tick(2'b10, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b00, 0, 2'd1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(2'b00, 1, 2'd3, 0, 0, 0, 0);
        check("stall_qtd", 8'(carga_qtd), 8'd1);
        tick(2'b00, 0, 2'd0, 0, 0, 1, 0);
        check("valid_drop", 8'(carga_valid), 8'd0);
        tick(2'b00, 0, 2'd0, 0, 0, 0, 0);

        // Saturation at 15
        tick(2'b11, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b11, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b10, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b10, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b10, 0, 2'd0, 0, 0, 0, 0);
        check("sat_saldo_14", 8'(saldo), 8'd14);
        check("sat_erro", 8'(erro), 8'd1);
        tick(2'b01, 0, 2'd0, 0, 0, 0, 0);
        check("sat_saldo_15", 8'(saldo), 8'd15);
        tick(2'b00, 0, 2'd3, 1, 0, 0, 0);
        tick(2'b10, 0, 2'd0, 0, 0, 0, 0);
        check("load_coin_erro", 8'(erro), 8'd1);
        check("load_coin_saldo", 8'(saldo), 8'd9);
        for (int i = 0; i < 11; i++) tick(2'b00, 0, 2'd0, 0, 0, 1, 0);

        // Cancel with 3 units
        tick(2'b01, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b10, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b00, 0, 2'd0, 0, 1, 0, 0);
`ifdef BILHETERIA_CANCELA_EN
        check("cancel_troco", 8'(estado_dbg), 8'd3);
`else
        check("cancel_ignored", 8'(estado_dbg), 8'd1);
        check("cancel_saldo", 8'(saldo), 8'd3);
`endif
        check("cancel_no_erro", 8'(erro), 8'd0);
        for (int i = 0; i < 4; i++) tick(2'b00, 0, 2'd0, 0, 0, 0, 0);

        // Reset in the middle of change payout
        tick(2'b00, 0, 2'd0, 0, 0, 0, 1);
        tick(2'b11, 0, 2'd0, 0, 0, 0, 0);
        tick(2'b00, 0, 2'd1, 1, 0, 0, 0);
        tick(2'b00, 0, 2'd0, 0, 0, 1, 0);
        tick(2'b00, 0, 2'd0, 0, 0, 0, 0);
        check("mid_troco", 8'(troco), 8'd1);
        tick(2'b01, 0, 2'd0, 1, 1, 1, 1);
        check("rst_estado", 8'(estado_dbg), 8'd0);
        check("rst_saldo", 8'(saldo), 8'd0);
        check("rst_troco", 8'(troco), 8'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] m;
            m = ($urandom_range(9) < 3) ? 2'($urandom_range(3, 1)) : 2'b00;
            tick(m, 1'($urandom_range(1)), 2'($urandom_range(3)),
                 ($urandom_range(4) == 0), ($urandom_range(19) == 0),
                 1'($urandom_range(1)), ($urandom_range(199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
